// File: rtl/tmr_err_monitor_if.sv
// Bus bundle between the TMR voters / refresh logic and tmr_err_monitor.
// The master side drives the error, clear and acknowledge inputs; the slave side
// (the monitor) drives the request and status outputs.
// Optional clear-on-read port set is included when TMR_ERR_CLR_ON_READ_EN is defined.
//
// Refresh handshake: scrub_req is a level request held high from the cycle after a
// scrub is triggered until the cycle after scrub_done is sampled high (or the wait
// times out). scrub_done is only looked at while scrub_req is high; a one-cycle
// pulse is enough, and a scrub_done sampled in the very first request cycle ends
// the request after a single cycle.
interface tmr_err_monitor_if #(
    parameter int NSRC  = 4,
    parameter int CNT_W = 16
);
    logic [NSRC-1:0]  tmr_err;
    logic             clr;
    logic             scrub_done;
    logic             scrub_req;
    logic [CNT_W-1:0] err_cnt;
    logic [NSRC-1:0]  err_mask;
    logic             err_flag;
    logic             scrub_fail;
    logic             fsm_state;   // debug: 0 = IDLE, 1 = REQ
`ifdef TMR_ERR_CLR_ON_READ_EN
    logic             rd_strb;
    logic [CNT_W-1:0] rd_cnt;
    logic [NSRC-1:0]  rd_mask;

    modport master (
        output tmr_err, clr, scrub_done, rd_strb,
        input  scrub_req, err_cnt, err_mask, err_flag, scrub_fail, fsm_state,
               rd_cnt, rd_mask
    );
    modport slave (
        input  tmr_err, clr, scrub_done, rd_strb,
        output scrub_req, err_cnt, err_mask, err_flag, scrub_fail, fsm_state,
               rd_cnt, rd_mask
    );
`else
    modport master (
        output tmr_err, clr, scrub_done,
        input  scrub_req, err_cnt, err_mask, err_flag, scrub_fail, fsm_state
    );
    modport slave (
        input  tmr_err, clr, scrub_done,
        output scrub_req, err_cnt, err_mask, err_flag, scrub_fail, fsm_state
    );
`endif
endinterface

// File: rtl/tmr_err_monitor.sv
// tmr_err_monitor: watches voter mismatch flags from triplicated registers.
//  - saturating upset counter (popcount of tmr_err per cycle)
//  - sticky per-source mask and registered any-error flag
//  - scrub FSM (IDLE/REQ) that requests a refresh on any error or periodically,
//    with a bounded wait for scrub_done and a sticky timeout flag.
// Optional feature macro: TMR_ERR_CLR_ON_READ_EN adds rd_strb / rd_cnt / rd_mask,
// a snapshot-and-clear read of the counter and mask.
module tmr_err_monitor #(
    parameter int NSRC           = 4,
    parameter int CNT_W          = 16,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int TIMEOUT        = 64
) (
    input  logic          clk,
    input  logic          rst,
    tmr_err_monitor_if.slave bus
);

    localparam int POP_W  = $clog2(NSRC + 1);
    localparam int SUM_W  = CNT_W + POP_W;
    localparam int TMR_W  = $clog2(SCRUB_INTERVAL);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    logic [POP_W-1:0] pop;
    logic             wipe;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] err_cnt_d,  err_cnt_q;
    logic [NSRC-1:0]  err_mask_d, err_mask_q;
    logic             err_flag_d, err_flag_q;

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [WAIT_W-1:0] wait_q;
    logic             scrub_req_q;
    logic             scrub_fail_q;

    // Number of sources flagging a mismatch this cycle.
    always_comb begin
        pop = '0;
        for (int i = 0; i < NSRC; i++) begin
            pop = pop + POP_W'(bus.tmr_err[i]);
        end
    end

    // Sources of a counter/mask clear; this cycle's errors are still added on top.
`ifdef TMR_ERR_CLR_ON_READ_EN
    assign wipe = bus.clr | bus.rd_strb;
`else
    assign wipe = bus.clr;
`endif

    // Next counter (saturating), sticky mask and flag.
    always_comb begin
        sum        = (wipe ? '0 : SUM_W'(err_cnt_q)) + SUM_W'(pop);
        err_cnt_d  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
        err_mask_d = (wipe ? '0 : err_mask_q) | bus.tmr_err;
        err_flag_d = |err_mask_d;
    end

    // Counter, mask and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q  <= '0;
            err_mask_q <= '0;
            err_flag_q <= 1'b0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            err_mask_q <= err_mask_d;
            err_flag_q <= err_flag_d;
        end
    end

    // Scrub FSM: IDLE runs the periodic timer, REQ holds scrub_req and bounds the wait.
    // Errors arriving during REQ are counted above but do not extend the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            wait_q       <= '0;
            scrub_req_q  <= 1'b0;
            scrub_fail_q <= 1'b0;
        end else begin
            // clr drops the sticky fail; a timeout in the same cycle re-sets it below.
            if (bus.clr) begin
                scrub_fail_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if ((|bus.tmr_err) || (timer_q == TMR_W'(SCRUB_INTERVAL - 1))) begin
                        state_q     <= ST_REQ;
                        scrub_req_q <= 1'b1;
                        timer_q     <= '0;
                        wait_q      <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_REQ: begin
                    // Done has priority over an expiring wait.
                    if (bus.scrub_done) begin
                        state_q     <= ST_IDLE;
                        scrub_req_q <= 1'b0;
                        timer_q     <= '0;
                    end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_q      <= ST_IDLE;
                        scrub_req_q  <= 1'b0;
                        timer_q      <= '0;
                        scrub_fail_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    scrub_req_q <= 1'b0;
                    timer_q     <= '0;
                end
            endcase
        end
    end

`ifdef TMR_ERR_CLR_ON_READ_EN
    logic [CNT_W-1:0] rd_cnt_d,  rd_cnt_q;
    logic [NSRC-1:0]  rd_mask_d, rd_mask_q;

    // Snapshot the pre-clear counter and mask on a read strobe; hold otherwise.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        rd_mask_d = rd_mask_q;
        if (bus.rd_strb) begin
            rd_cnt_d  = err_cnt_q;
            rd_mask_d = err_mask_q;
        end
    end

    // Read snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            rd_mask_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            rd_mask_q <= rd_mask_d;
        end
    end

    assign bus.rd_cnt  = rd_cnt_q;
    assign bus.rd_mask = rd_mask_q;
`endif

    assign bus.scrub_req  = scrub_req_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.err_mask   = err_mask_q;
    assign bus.err_flag   = err_flag_q;
    assign bus.scrub_fail = scrub_fail_q;
    assign bus.fsm_state  = (state_q == ST_REQ);

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Bench for tmr_err_monitor: directed scenarios plus a randomized run, all checked
// against a cycle-level reference model built from the monitor's rules.
module tb_tmr_err_monitor;

    localparam int NSRC = 4;
    localparam int CNT_W = 4;
    localparam int SI = 1024;
    localparam int TO = 64;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tmr_err_monitor_if #(.NSRC(NSRC), .CNT_W(CNT_W)) bus();

    tmr_err_monitor #(
        .NSRC(NSRC), .CNT_W(CNT_W), .SCRUB_INTERVAL(SI), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state
    int              m_cnt;
    logic [NSRC-1:0] m_mask;
    bit              m_req;
    bit              m_fail;
    int              m_idle;   // idle cycles since reset / end of last scrub
    int              m_held;   // cycles scrub_req has been high in this scrub
    int              m_rd_cnt;
    logic [NSRC-1:0] m_rd_mask;

    task automatic model_reset();
        m_cnt = 0; m_mask = '0; m_req = 0; m_fail = 0; m_idle = 0; m_held = 0;
        m_rd_cnt = 0; m_rd_mask = '0;
    endtask

    task automatic drive_idle();
        bus.tmr_err = '0; bus.clr = 1'b0; bus.scrub_done = 1'b0;
`ifdef TMR_ERR_CLR_ON_READ_EN
        bus.rd_strb = 1'b0;
`endif
    endtask

    // Advance model and DUT one clock using the inputs currently driven; returns at negedge.
    task automatic tick();
        logic [NSRC-1:0] e;
        bit wipe;
        e = bus.tmr_err;
        wipe = bus.clr;
`ifdef TMR_ERR_CLR_ON_READ_EN
        if (bus.rd_strb) begin
            m_rd_cnt = m_cnt; m_rd_mask = m_mask; wipe = 1;
        end
`endif
        m_cnt = (wipe ? 0 : m_cnt) + $countones(e);
        if (m_cnt > CMAX) m_cnt = CMAX;
        m_mask = (wipe ? '0 : m_mask) | e;
        if (bus.clr) m_fail = 0;
        if (!m_req) begin
            if (e != '0 || m_idle + 1 == SI) begin
                m_req = 1; m_held = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end else if (bus.scrub_done) begin
            m_req = 0; m_idle = 0;
        end else if (m_held == TO) begin
            m_req = 0; m_idle = 0; m_fail = 1;
        end else begin
            m_held++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive_idle();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.scrub_req, bus.err_cnt, bus.err_mask, bus.err_flag, bus.scrub_fail} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b cnt=%0d mask=%b flag=%b fail=%b exp all 0",
                     bus.scrub_req, bus.err_cnt, bus.err_mask, bus.err_flag, bus.scrub_fail);
        end
        rst = 1'b0;
    endtask

    task automatic test_periodic_scrub();
        int early;
        for (int round = 0; round < 2; round++) begin
            early = 0;
            for (int i = 0; i < SI - 1; i++) begin
                tick();
                if (bus.scrub_req !== 1'b0) early++;
            end
            n_checks++;
            if (early != 0) begin
                n_fail++;
                $display("FAIL periodic_early round=%0d got %0d early req cycles exp 0", round, early);
            end
            tick();
            n_checks++;
            if (bus.scrub_req !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic_req round=%0d got %b exp 1", round, bus.scrub_req);
            end
            tick();
            tick();
            n_checks++;
            if (bus.scrub_req !== 1'b1) begin
                n_fail++;
                $display("FAIL periodic_hold round=%0d got %b exp 1", round, bus.scrub_req);
            end
            bus.scrub_done = 1'b1;
            tick();
            bus.scrub_done = 1'b0;
            n_checks++;
            if (bus.scrub_req !== 1'b0 || bus.err_cnt !== '0) begin
                n_fail++;
                $display("FAIL periodic_done round=%0d got req=%b cnt=%0d exp req=0 cnt=0",
                         round, bus.scrub_req, bus.err_cnt);
            end
        end
    endtask

    task automatic test_single_error();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        bus.tmr_err = 4'b0101; tick(); bus.tmr_err = '0;
        n_checks++;
        if (bus.err_cnt !== 4'd2 || bus.err_mask !== 4'b0101 || bus.err_flag !== 1'b1
            || bus.scrub_req !== 1'b1) begin
            n_fail++;
            $display("FAIL single_error got cnt=%0d mask=%b flag=%b req=%b exp 2 0101 1 1",
                     bus.err_cnt, bus.err_mask, bus.err_flag, bus.scrub_req);
        end
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
        n_checks++;
        if (bus.scrub_req !== 1'b0 || bus.err_mask !== 4'b0101) begin
            n_fail++;
            $display("FAIL single_error_done got req=%b mask=%b exp 0 0101", bus.scrub_req, bus.err_mask);
        end
    endtask

    task automatic test_saturation();
        int exp_seq[5] = '{4, 8, 12, 15, 15};
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        bus.tmr_err = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bus.err_cnt !== CNT_W'(exp_seq[i]) || bus.err_cnt !== CNT_W'(m_cnt)) begin
                n_fail++;
                $display("FAIL saturation step=%0d got %0d exp %0d", i, bus.err_cnt, exp_seq[i]);
            end
        end
        bus.tmr_err = '0;
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
    endtask

    task automatic test_clr_priority();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        bus.tmr_err = 4'b1111; tick(); tick();
        bus.tmr_err = 4'b0001; tick();
        n_checks++;
        if (bus.err_cnt !== 4'd9) begin
            n_fail++;
            $display("FAIL clr_prior_setup got cnt=%0d exp 9", bus.err_cnt);
        end
        bus.clr = 1'b1; bus.tmr_err = 4'b0010; tick();
        bus.clr = 1'b0; bus.tmr_err = '0;
        n_checks++;
        if (bus.err_cnt !== 4'd1 || bus.err_mask !== 4'b0010 || bus.err_flag !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_priority got cnt=%0d mask=%b flag=%b exp 1 0010 1",
                     bus.err_cnt, bus.err_mask, bus.err_flag);
        end
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
    endtask

    task automatic test_timeout();
        int highs;
        bus.tmr_err = 4'b0001; tick(); bus.tmr_err = '0;
        highs = (bus.scrub_req === 1'b1) ? 1 : 0;
        while (bus.scrub_req === 1'b1 && highs < 200) begin
            tick();
            if (bus.scrub_req === 1'b1) highs++;
        end
        n_checks++;
        if (highs != TO) begin
            n_fail++;
            $display("FAIL timeout_len got %0d req cycles exp %0d", highs, TO);
        end
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (bus.scrub_fail !== 1'b1 || bus.scrub_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky got fail=%b req=%b exp 1 0", bus.scrub_fail, bus.scrub_req);
        end
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        n_checks++;
        if (bus.scrub_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clr got fail=%b exp 0", bus.scrub_fail);
        end
    endtask

    task automatic test_done_vs_timeout();
        bus.tmr_err = 4'b0100; tick(); bus.tmr_err = '0;
        for (int i = 0; i < TO - 1; i++) tick();
        n_checks++;
        if (bus.scrub_req !== 1'b1) begin
            n_fail++;
            $display("FAIL done_vs_to_pre got req=%b exp 1", bus.scrub_req);
        end
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
        n_checks++;
        if (bus.scrub_req !== 1'b0 || bus.scrub_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL done_vs_timeout got req=%b fail=%b exp 0 0", bus.scrub_req, bus.scrub_fail);
        end
    endtask

    task automatic test_retrigger();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        bus.tmr_err = 4'b1000;
        tick(); tick(); tick();
        n_checks++;
        if (bus.scrub_req !== 1'b1 || bus.err_cnt !== 4'd3) begin
            n_fail++;
            $display("FAIL retrig_hold got req=%b cnt=%0d exp 1 3", bus.scrub_req, bus.err_cnt);
        end
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
        n_checks++;
        if (bus.scrub_req !== 1'b0) begin
            n_fail++;
            $display("FAIL retrig_exit got req=%b exp 0", bus.scrub_req);
        end
        tick();
        n_checks++;
        if (bus.scrub_req !== 1'b1 || bus.err_cnt !== 4'd5) begin
            n_fail++;
            $display("FAIL retrig_again got req=%b cnt=%0d exp 1 5", bus.scrub_req, bus.err_cnt);
        end
        bus.tmr_err = '0;
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
    endtask

    task automatic test_done_in_idle();
        int bad;
        bad = 0;
        bus.scrub_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.scrub_req !== 1'b0 || bus.scrub_req !== m_req) bad++;
        end
        bus.scrub_done = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL done_in_idle got %0d cycles with req set exp 0", bad);
        end
    endtask

`ifdef TMR_ERR_CLR_ON_READ_EN
    task automatic test_clear_on_read();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        bus.tmr_err = 4'b1111; tick();
        bus.tmr_err = 4'b0111; tick();
        bus.tmr_err = '0;
        bus.rd_strb = 1'b1; tick(); bus.rd_strb = 1'b0;
        n_checks++;
        if (bus.rd_cnt !== 4'd7 || bus.rd_mask !== 4'b1111 || bus.err_cnt !== 4'd0
            || bus.err_mask !== 4'b0000) begin
            n_fail++;
            $display("FAIL clear_on_read got rd_cnt=%0d rd_mask=%b cnt=%0d mask=%b exp 7 1111 0 0000",
                     bus.rd_cnt, bus.rd_mask, bus.err_cnt, bus.err_mask);
        end
        bus.tmr_err = 4'b0011; tick();
        bus.tmr_err = 4'b0100; bus.rd_strb = 1'b1; tick();
        bus.tmr_err = '0; bus.rd_strb = 1'b0;
        n_checks++;
        if (bus.rd_cnt !== 4'd2 || bus.rd_mask !== 4'b0011 || bus.err_cnt !== 4'd1
            || bus.err_mask !== 4'b0100) begin
            n_fail++;
            $display("FAIL read_with_err got rd_cnt=%0d rd_mask=%b cnt=%0d mask=%b exp 2 0011 1 0100",
                     bus.rd_cnt, bus.rd_mask, bus.err_cnt, bus.err_mask);
        end
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bus.tmr_err    = ($urandom_range(0, 9) == 0) ? NSRC'($urandom_range(0, 15)) : '0;
            bus.scrub_done = ($urandom_range(0, 3) == 0);
            bus.clr        = ($urandom_range(0, 49) == 0);
`ifdef TMR_ERR_CLR_ON_READ_EN
            bus.rd_strb    = ($urandom_range(0, 29) == 0);
`endif
            tick();
            n_checks++;
            if ({bus.scrub_req, bus.err_cnt, bus.err_mask, bus.err_flag, bus.scrub_fail}
                !== {m_req, CNT_W'(m_cnt), m_mask, |m_mask, m_fail}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got req=%b cnt=%0d mask=%b flag=%b fail=%b exp %b %0d %b %b %b",
                         i, bus.scrub_req, bus.err_cnt, bus.err_mask, bus.err_flag, bus.scrub_fail,
                         m_req, m_cnt, m_mask, |m_mask, m_fail);
            end
`ifdef TMR_ERR_CLR_ON_READ_EN
            n_checks++;
            if (bus.rd_cnt !== CNT_W'(m_rd_cnt) || bus.rd_mask !== m_rd_mask) begin
                n_fail++;
                $display("FAIL random_rd cyc=%0d got %0d %b exp %0d %b",
                         i, bus.rd_cnt, bus.rd_mask, m_rd_cnt, m_rd_mask);
            end
`endif
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_req();
        bus.scrub_done = 1'b1; tick(); bus.scrub_done = 1'b0;
        bus.tmr_err = 4'b0110; tick(); bus.tmr_err = '0;
        tick();
        n_checks++;
        if (bus.scrub_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req_pre got req=%b exp 1", bus.scrub_req);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.scrub_req !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_req got req=%b exp 0", bus.scrub_req);
        end
        model_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.scrub_req, bus.err_cnt, bus.err_mask, bus.err_flag, bus.scrub_fail} !== '0) begin
            n_fail++;
            $display("FAIL mid_req_reset got req=%b cnt=%0d mask=%b flag=%b fail=%b exp all 0",
                     bus.scrub_req, bus.err_cnt, bus.err_mask, bus.err_flag, bus.scrub_fail);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (bus.scrub_req !== 1'b0 || bus.err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL after_reset got req=%b cnt=%0d exp 0 0", bus.scrub_req, bus.err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_periodic_scrub();
        test_single_error();
        test_saturation();
        test_clr_priority();
        test_timeout();
        test_done_vs_timeout();
        test_retrigger();
        test_done_in_idle();
`ifdef TMR_ERR_CLR_ON_READ_EN
        test_clear_on_read();
`endif
        test_random();
        test_reset_mid_req();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
